// File: rtl/prod_accumulator_pkg.sv
// Shared types and constants for the product accumulator.
package prod_accumulator_pkg;

  // Control states of the accumulator.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int ACC_W_DEFAULT = 24;
  localparam int LEN_W_DEFAULT = 4;
  localparam int PROD_W        = 16;

  // Saturation limits at the default accumulator width.
  localparam logic [ACC_W_DEFAULT-1:0] SAT_MAX_DEFAULT = {1'b0, {(ACC_W_DEFAULT-1){1'b1}}};
  localparam logic [ACC_W_DEFAULT-1:0] SAT_MIN_DEFAULT = {1'b1, {(ACC_W_DEFAULT-1){1'b0}}};

endpackage

// File: rtl/prod_accumulator_sat_add.sv
// Combinational saturating adder: ACC_W signed accumulator plus a 16-bit
// signed product, summed at ACC_W+1 bits and clamped back to ACC_W.
module sat_add
  import prod_accumulator_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PROD_W-1:0] addend,
  output logic [ACC_W-1:0]  sum,
  output logic              ovf
);

  localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [ACC_W:0] wide;

  // Add with one guard bit; differing top two bits mean the result left range.
  always_comb begin
    wide = {acc[ACC_W-1], acc} + {{(ACC_W+1-PROD_W){addend[PROD_W-1]}}, addend};
    if (wide[ACC_W] != wide[ACC_W-1]) begin
      ovf = 1'b1;
      sum = wide[ACC_W] ? SAT_MIN : SAT_MAX;
    end else begin
      ovf = 1'b0;
      sum = wide[ACC_W-1:0];
    end
  end

endmodule

// File: rtl/prod_accumulator.sv
// Dot-product accumulator: sums len signed 16-bit products with saturation,
// then holds the result until downstream accepts it.
module prod_accumulator
  import prod_accumulator_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int LEN_W = LEN_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  output logic              busy,
  output logic              ovf
);

  state_t           state;
  logic [LEN_W-1:0] cnt;
  logic [ACC_W-1:0] sum;
  logic             add_ovf;

  sat_add #(.ACC_W(ACC_W)) u_sat_add (
    .acc    (acc_out),
    .addend (prod_in),
    .sum    (sum),
    .ovf    (add_ovf)
  );

  // Control FSM; acc_out itself is the accumulator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      acc_out   <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      acc_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc_out <= '0;
            ovf     <= 1'b0;
            busy    <= 1'b1;
            cnt     <= len;
            if (len == '0) begin
              // Empty dot product: present a zero result right away.
              state     <= HOLD;
              acc_valid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          // Bubbles (prod_valid low) leave acc and cnt untouched.
          if (prod_valid) begin
            acc_out <= sum;
            ovf     <= ovf | add_ovf;
            cnt     <= cnt - LEN_W'(1);
            if (cnt == LEN_W'(1)) begin
              state     <= HOLD;
              acc_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          // start is deliberately not looked at here, even alongside out_ready.
          if (out_ready) begin
            state     <= IDLE;
            acc_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          acc_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prod_accumulator.sv
// Self-checking bench: a 24-bit and a 17-bit accumulator driven in lockstep,
// expected results queued at start and compared when acc_valid appears.
module tb_prod_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  len;
  logic [15:0] prod_in;
  logic        prod_valid;
  logic        out_ready;

  logic [23:0] acc_out24;
  logic        acc_valid24, busy24, ovf24;
  logic [16:0] acc_out17;
  logic        acc_valid17, busy17, ovf17;

  prod_accumulator #(.ACC_W(24), .LEN_W(4)) dut24 (
    .clk(clk), .rst(rst), .start(start), .len(len), .prod_in(prod_in),
    .prod_valid(prod_valid), .out_ready(out_ready), .acc_out(acc_out24),
    .acc_valid(acc_valid24), .busy(busy24), .ovf(ovf24)
  );

  prod_accumulator #(.ACC_W(17), .LEN_W(4)) dut17 (
    .clk(clk), .rst(rst), .start(start), .len(len), .prod_in(prod_in),
    .prod_valid(prod_valid), .out_ready(out_ready), .acc_out(acc_out17),
    .acc_valid(acc_valid17), .busy(busy17), .ovf(ovf17)
  );

  always #5 clk = ~clk;

  typedef struct {
    int acc;
    bit ovf;
  } res_t;

  typedef struct {
    logic [3:0]       len;
    logic [3:0][15:0] p;
    int               e24;
    int               e17;
    bit               o24;
    bit               o17;
  } vec_t;

  res_t q24[$];
  res_t q17[$];
  vec_t vecs[8];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input int l, input int p0, input int p1, input int p2,
                              input int p3, input int e24, input int e17,
                              input bit o24, input bit o17);
    vec_t v;
    v.len  = 4'(l);
    v.p[0] = 16'(p0);
    v.p[1] = 16'(p1);
    v.p[2] = 16'(p2);
    v.p[3] = 16'(p3);
    v.e24  = e24;
    v.e17  = e17;
    v.o24  = o24;
    v.o17  = o17;
    return v;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Pulse start for one cycle; optionally queue the expected results.
  task automatic start_run(input logic [3:0] l, input int e24, input int e17,
                           input bit o24, input bit o17, input bit push);
    res_t r;
    @(negedge clk);
    start = 1'b1;
    len   = l;
    if (push) begin
      r.acc = e24; r.ovf = o24; q24.push_back(r);
      r.acc = e17; r.ovf = o17; q17.push_back(r);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input logic [15:0] p);
    prod_valid = 1'b1;
    prod_in    = p;
    @(negedge clk);
  endtask

  // Wait (bounded) for the result, compare against the queue, optionally stall
  // in HOLD while poking start/prod_valid, then release with out_ready.
  task automatic get_result(input int stall);
    int   w = 0;
    res_t e24;
    res_t e17;
    prod_valid = 1'b0;
    while (!(acc_valid24 && acc_valid17) && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("valid_latency", w, 0);
    if (q24.size() == 0 || q17.size() == 0) begin
      check("sb_nonempty", 0, 1);
      return;
    end
    e24 = q24.pop_front();
    e17 = q17.pop_front();
    check("acc24", $signed(acc_out24), e24.acc);
    check("ovf24", int'(ovf24), int'(e24.ovf));
    check("acc17", $signed(acc_out17), e17.acc);
    check("ovf17", int'(ovf17), int'(e17.ovf));
    check("busy_hold", int'(busy24 & busy17), 1);
    for (int i = 0; i < stall; i++) begin
      start      = 1'(i % 2 == 0);
      len        = 4'd2;
      prod_valid = 1'b1;
      prod_in    = 16'h7fff;
      @(negedge clk);
      check("hold_acc24", $signed(acc_out24), e24.acc);
      check("hold_valid", int'(acc_valid24 & acc_valid17), 1);
      check("hold_ovf17", int'(ovf17), int'(e17.ovf));
    end
    start      = (stall > 0);
    prod_valid = 1'b0;
    out_ready  = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    out_ready = 1'b0;
    check("rel_valid", int'(acc_valid24 | acc_valid17), 0);
    check("rel_busy", int'(busy24 | busy17), 0);
    check("rel_acc24", $signed(acc_out24), e24.acc);
    @(negedge clk);
    check("idle_busy", int'(busy24 | busy17), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; len = 4'd0; prod_in = 16'd0;
    prod_valid = 1'b0; out_ready = 1'b0;

    vecs[0] = mk(3, 100, -50, 25, 0, 75, 75, 1'b0, 1'b0);
    vecs[1] = mk(3, -32768, -32768, -32768, 0, -98304, -65536, 1'b0, 1'b1);
    vecs[2] = mk(3, 32767, 32767, 32767, 0, 98301, 65535, 1'b0, 1'b1);
    vecs[3] = mk(1, 5, 0, 0, 0, 5, 5, 1'b0, 1'b0);
    vecs[4] = mk(2, 7, 9, 0, 0, 16, 16, 1'b0, 1'b0);
    vecs[5] = mk(4, 1000, -2000, 3000, -4000, -2000, -2000, 1'b0, 1'b0);
    vecs[6] = mk(4, 32767, 32767, -32768, 1, 32767, 32767, 1'b0, 1'b0);
    vecs[7] = mk(4, 32767, 32767, 32767, -32768, 65533, 32767, 1'b0, 1'b1);

    // Reset state.
    #1;
    check("rst_acc24", int'(acc_out24), 0);
    check("rst_acc17", int'(acc_out17), 0);
    check("rst_valid", int'(acc_valid24 | acc_valid17), 0);
    check("rst_busy", int'(busy24 | busy17), 0);
    check("rst_ovf", int'(ovf24 | ovf17), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven runs; the first one also stalls in HOLD with start pulses.
    for (int i = 0; i < 8; i++) begin
      start_run(vecs[i].len, vecs[i].e24, vecs[i].e17, vecs[i].o24, vecs[i].o17, 1'b1);
      for (int j = 0; j < int'(vecs[i].len); j++) feed(vecs[i].p[j]);
      get_result(i == 0 ? 5 : 0);
    end

    // Empty dot product after a non-zero result.
    start_run(4'd0, 0, 0, 1'b0, 1'b0, 1'b1);
    get_result(0);

    // Bubbles between products.
    start_run(4'd2, 16, 16, 1'b0, 1'b0, 1'b1);
    feed(16'd7);
    prod_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bubble_cnt", int'(dut24.cnt), 1);
      check("bubble_acc", $signed(acc_out24), 7);
      check("bubble_valid", int'(acc_valid24), 0);
    end
    feed(16'd9);
    get_result(0);

    // Longest run: 15 products, no counter wrap.
    start_run(4'd15, 15, 15, 1'b0, 1'b0, 1'b1);
    for (int j = 0; j < 15; j++) feed(16'd1);
    get_result(0);

    // Reset part-way through a 4-product run, then restart immediately.
    start_run(4'd4, 0, 0, 1'b0, 1'b0, 1'b0);
    feed(16'd100);
    feed(16'd200);
    prod_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_acc", int'(acc_out24), 0);
    check("mid_rst_valid", int'(acc_valid24 | acc_valid17), 0);
    check("mid_rst_busy", int'(busy24 | busy17), 0);
    @(negedge clk);
    check("mid_rst_noemit", int'(acc_valid24 | acc_valid17), 0);
    begin
      res_t r;
      rst   = 1'b0;
      start = 1'b1;
      len   = 4'd1;
      r.acc = 5; r.ovf = 1'b0;
      q24.push_back(r);
      q17.push_back(r);
    end
    @(negedge clk);
    start = 1'b0;
    check("post_rst_busy", int'(busy24 & busy17), 1);
    feed(16'd5);
    get_result(0);

    check("sb_empty", q24.size() + q17.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
